// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pkg
// Description : Shared types and constants for the LED pattern generator.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    typedef enum logic [1:0] {
        MODE_UP     = 2'd0,
        MODE_DOWN   = 2'd1,
        MODE_ROTATE = 2'd2,
        MODE_BOUNCE = 2'd3
    } led_mode_t;

    localparam int PWM_W = 8;

    localparam logic [PWM_W-1:0] DUTY_RESET = 8'hFF;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // DOWN seeds with all-ones; the width-dependent value is built in the top.
    localparam int unsigned SEED_UP     = 0;
    localparam int unsigned SEED_ONEHOT = 1;

endpackage
`default_nettype wire

// File: rtl/led_pattern_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_gen_if
// Description : valid/ready configuration port (step, mode, duty).
// Revision    : 1.0 - initial release
// ============================================================================
interface led_pattern_gen_if #(
    parameter int STEP_W = 32
);
    logic                        CFG_VALID;
    logic                        CFG_READY;
    logic [STEP_W-1:0]           CFG_STEP;
    logic [1:0]                  CFG_MODE;
    logic [led_pkg::PWM_W-1:0]   CFG_DUTY;

    modport master (
        output CFG_VALID,
        output CFG_STEP,
        output CFG_MODE,
        output CFG_DUTY,
        input  CFG_READY
    );

    modport slave (
        input  CFG_VALID,
        input  CFG_STEP,
        input  CFG_MODE,
        input  CFG_DUTY,
        output CFG_READY
    );
endinterface
`default_nettype wire

// File: rtl/led_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : led_prescaler
// Description : Programmable period counter producing a one-cycle tick.
// Revision    : 1.0 - initial release
// ============================================================================
module led_prescaler #(
    parameter int STEP_W = 32
) (
    input  wire logic              CLK,
    input  wire logic              RST_N,
    input  wire logic              en,
    input  wire logic              clr,
    input  wire logic [STEP_W-1:0] step,
    output logic                   tick
);

    logic [STEP_W-1:0] cnt_q;
    logic [STEP_W-1:0] cnt_d;
    logic [STEP_W-1:0] last;
    logic              wrap;

    always_comb begin
        // A zero step behaves as a step of one: wrap on every enabled cycle.
        last = (step == '0) ? '0 : step - STEP_W'(1);
        // >= keeps the counter bounded even if step shrinks below the count.
        wrap = (cnt_q >= last);
        tick = RST_N && en && !clr && wrap;

        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = wrap ? '0 : cnt_q + STEP_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_gen
// Description : WIDTH-bit LED pattern generator (UP/DOWN/ROTATE/BOUNCE) with
//               runtime config port; LED_PWM_EN adds a duty-cycle PWM mask.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int          WIDTH        = 8,
    parameter int          STEP_W       = 32,
    parameter int unsigned DEFAULT_STEP = 10
) (
    input  wire logic       CLK,
    input  wire logic       RST_N,
    input  wire logic       PAUSE,
    led_pattern_gen_if.slave cfg,
    output logic             TICK,
    output logic [WIDTH-1:0] LED
);

    logic              ready_q, ready_d;
    logic [STEP_W-1:0] step_q, step_d;
    led_mode_t         mode_q, mode_d;
    logic              dir_q, dir_d;
    logic [WIDTH-1:0]  pat_q, pat_d;
    logic [WIDTH-1:0]  pat_rot;
    logic              transfer;
    logic              presc_tick;
    led_mode_t         cfg_mode;

    assign cfg_mode      = led_mode_t'(cfg.CFG_MODE);
    assign transfer      = cfg.CFG_VALID && ready_q;
    assign cfg.CFG_READY = ready_q;
    assign TICK          = presc_tick;

    led_prescaler #(
        .STEP_W (STEP_W)
    ) u_prescaler (
        .CLK   (CLK),
        .RST_N (RST_N),
        .en    (!PAUSE),
        .clr   (transfer),
        .step  (step_q),
        .tick  (presc_tick)
    );

    generate
        if (WIDTH == 1) begin : g_rot_w1
            assign pat_rot = pat_q;
        end else begin : g_rot_wn
            assign pat_rot = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
        end
    endgenerate

    always_comb begin
        ready_d = !transfer;
        step_d  = step_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        pat_d   = pat_q;

        // A transfer takes priority over a coincident tick; the prescaler
        // suppresses that tick via clr.
        if (transfer) begin
            step_d = cfg.CFG_STEP;
            mode_d = cfg_mode;
            dir_d  = DIR_LEFT;
            case (cfg_mode)
                MODE_UP:   pat_d = WIDTH'(SEED_UP);
                MODE_DOWN: pat_d = '1;
                default:   pat_d = WIDTH'(SEED_ONEHOT);
            endcase
        end else if (presc_tick) begin
            case (mode_q)
                MODE_UP:     pat_d = pat_q + WIDTH'(1);
                MODE_DOWN:   pat_d = pat_q - WIDTH'(1);
                MODE_ROTATE: pat_d = pat_rot;
                default: begin
                    // The end bit turns the walk around on the same advance.
                    if (WIDTH > 1) begin
                        if (dir_q == DIR_LEFT) begin
                            if (pat_q[WIDTH-1]) begin
                                pat_d = pat_q >> 1;
                                dir_d = DIR_RIGHT;
                            end else begin
                                pat_d = pat_q << 1;
                            end
                        end else begin
                            if (pat_q[0]) begin
                                pat_d = pat_q << 1;
                                dir_d = DIR_LEFT;
                            end else begin
                                pat_d = pat_q >> 1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ready_q <= 1'b0;
            step_q  <= STEP_W'(DEFAULT_STEP);
            mode_q  <= MODE_UP;
            dir_q   <= DIR_LEFT;
            pat_q   <= '0;
        end else begin
            ready_q <= ready_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            pat_q   <= pat_d;
        end
    end

`ifdef LED_PWM_EN
    logic [PWM_W-1:0] duty_q, duty_d;
    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [WIDTH-1:0] led_q, led_d;

    always_comb begin
        duty_d    = transfer ? cfg.CFG_DUTY : duty_q;
        pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
        led_d     = pat_q & {WIDTH{pwm_cnt_q < duty_q}};
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            duty_q    <= DUTY_RESET;
            pwm_cnt_q <= '0;
            led_q     <= '0;
        end else begin
            duty_q    <= duty_d;
            pwm_cnt_q <= pwm_cnt_d;
            led_q     <= led_d;
        end
    end

    assign LED = led_q;
`else
    assign LED = pat_q;
`endif

endmodule
`default_nettype wire

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised successor to the fixed-step LED counter: drives a WIDTH-bit LED bank from a programmable prescaler with four selectable patterns.
- Runtime step and mode loaded through a valid/ready config port; PAUSE input freezes the pattern.
- Sits at the top level between board-control logic and the LED pins; a TICK strobe is exported for other status logic.

Parameters:
- WIDTH, 8, LED bank width (>=1).
- STEP_W, 32, width of the prescaler step and counter.
- DEFAULT_STEP, 10, step value loaded at reset.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RST_N  input  1  synchronous reset, active-low.
- PAUSE  input  1  high: prescaler and pattern hold.
- CFG_VALID  input  1  config request.
- CFG_READY  output  1  config may be accepted this cycle.
- CFG_STEP  input  STEP_W  new prescaler period in cycles.
- CFG_MODE  input  2  0 = UP, 1 = DOWN, 2 = ROTATE, 3 = BOUNCE.
- CFG_DUTY  input  8  PWM duty; ignored unless LED_PWM_EN is defined.
- TICK  output  1  one-cycle pulse on each pattern advance.
- LED  output  WIDTH  LED drive, registered.

Behaviour:
- Reset (RST_N low at posedge):
  - LED = 0, TICK = 0, CFG_READY = 0.
  - step = DEFAULT_STEP, mode = UP, prescaler = 0, dir = left, duty = 8'hFF.
- The cycle after reset deasserts, CFG_READY = 1.
- Prescaler:
  - Counts 0..step-1 while PAUSE is low.
  - At step-1 it wraps to 0; TICK = 1 that same cycle; LED advances on the same edge.
  - Step 0 is treated as 1, giving a tick every cycle.
  - Step is compared at full STEP_W width; no truncation.
- Pattern advance, per TICK:
  - UP: LED + 1, mod 2^WIDTH.
  - DOWN: LED - 1, mod 2^WIDTH.
  - ROTATE: rotate left by 1; an all-zero LED stays 0.
  - BOUNCE: one-hot shift in dir. Flip dir on reaching bit WIDTH-1 (going left) or bit 0 (going right). Direction flips on the endpoint itself, not one cycle later. Sequence for WIDTH=4: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, ...
  - WIDTH = 1: ROTATE and BOUNCE hold LED.
- Config handshake:
  - Transfer occurs when CFG_VALID && CFG_READY at a posedge.
  - On transfer, latch step/mode/duty, clear the prescaler, load the seed:
    - UP: 0
    - DOWN: all-ones
    - ROTATE and BOUNCE: 1, with dir = left
  - CFG_READY drops for exactly the next cycle (apply cycle), then returns high.
  - CFG_VALID during the apply cycle is not accepted; the master holds it.
- Simultaneous events:
  - Transfer in the same cycle as a wrap: the transfer wins, LED takes the seed, and TICK is suppressed.
  - PAUSE high: TICK = 0, counter and LED frozen; config still accepted and the seed is applied.
- Reset mid-operation: full return to reset values on the next edge, with no partial pattern.

Optional Feature:
- Macro LED_PWM_EN.
- Defined:
  - 8-bit free-running PWM counter, cleared at reset and not affected by PAUSE.
  - LED = pattern & {WIDTH{pwm_cnt < duty}}, registered, one cycle later than the pattern register.
  - Duty 0 gives fully off; 255 gives 255/256 on.
- Undefined: LED = pattern register directly; CFG_DUTY unused, no PWM counter.

Decomposition:
- Package led_pkg holds:
  - led_mode_t enum: MODE_UP, MODE_DOWN, MODE_ROTATE, MODE_BOUNCE.
  - localparam PWM_W = 8.
  - Seed constants.
- Sub-module led_prescaler:
  - Parameter STEP_W.
  - Inputs: CLK, RST_N, en (= !PAUSE), clr, step.
  - Output: tick.
  - Contains the zero-step guard.
- Top holds the config handshake, pattern/direction registers and optional PWM.

Test Plan:
- Reset, then idle with WIDTH = 8, DEFAULT_STEP = 10: TICK at cycles 10, 20, 30 after reset release; LED = 1, 2, 3; after 2560 cycles LED wraps to 0.
- Config STEP = 3, MODE = DOWN: CFG_READY low one cycle after the transfer; LED = FF then FE, FD on ticks every 3 cycles; STEP = 0 gives a decrement every cycle.
- Config MODE = BOUNCE, STEP = 1, WIDTH = 4 build: LED = 1, 2, 4, 8, 4, 2, 1, 2 on consecutive cycles.
- PAUSE high for 7 cycles mid-count: LED and prescaler frozen, no TICK; on release the count resumes from the frozen value.
- Transfer coinciding with a wrap: no TICK, LED = seed. RST_N low mid-BOUNCE: next cycle LED = 0, mode = UP, CFG_READY = 0.
- With LED_PWM_EN, DUTY = 64, pattern = FF: LED high 64 of every 256 cycles. DUTY = 0: LED always 0.
